// File: rtl/tetris_pkg.sv
// Shared types and helpers for the Tetris executor stages.
package tetris_pkg;

  // Executor stage states, common to all executor blocks.
  typedef enum logic [1:0] {
    eIDLE = 2'd0,
    eSCAN = 2'd1,
    eFILL = 2'd2,
    eDONE = 2'd3
  } exec_state_e;

  // Widest board row any executor stage supports.
  localparam int MAX_ROW_W = 16;

  // A row is full when every one of its `width` low bits is set.
  function automatic logic row_full(input logic [MAX_ROW_W-1:0] row, input int width);
    logic f;
    f = 1'b1;
    for (int i = 0; i < MAX_ROW_W; i++) begin
      if (i < width) f = f & row[i];
    end
    return f;
  endfunction

endpackage

// File: rtl/executor_line_clear.sv
// Line-clear stage: scans the board bottom-to-top, drops full rows,
// compacts the survivors downward and zero-fills the vacated top rows.
module executor_line_clear
  import tetris_pkg::*;
#(
  parameter int height_p = 32,
  parameter int width_p  = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          v_i,
  output logic                          ready_o,
  output logic [$clog2(height_p)-1:0]   read_addr_o,
  input  logic [width_p-1:0]            read_data_i,
  output logic                          write_v_o,
  output logic [$clog2(height_p)-1:0]   write_addr_o,
  output logic [width_p-1:0]            write_data_o,
  output logic                          done_o,
  output logic [$clog2(height_p+1)-1:0] lines_o
);

  localparam int AW = $clog2(height_p);
  localparam int CW = $clog2(height_p + 1);
  localparam logic [AW-1:0] LAST_ROW = AW'(height_p - 1);

  exec_state_e   state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          src_done_q, src_done_d;
  logic          full;

  assign full        = row_full(MAX_ROW_W'(read_data_i), width_p);
  assign read_addr_o = src_q;
  // The counter is cleared only on accept, so it holds the result until then.
  assign lines_o     = cnt_q;

  // Next-state, pointer updates and board write port.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    cnt_d        = cnt_q;
    src_done_d   = src_done_q;
    ready_o      = 1'b0;
    write_v_o    = 1'b0;
    write_addr_o = '0;
    write_data_o = '0;
    done_o       = 1'b0;
    case (state_q)
      eIDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          src_d      = LAST_ROW;
          dst_d      = LAST_ROW;
          cnt_d      = '0;
          src_done_d = 1'b0;
          state_d    = eSCAN;
        end
      end
      eSCAN: begin
        if (full) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          // A row that is already in place needs no write.
          if (src_q != dst_q) begin
            write_v_o    = 1'b1;
            write_addr_o = dst_q;
            write_data_o = read_data_i;
          end
          if (dst_q != '0) dst_d = dst_q - AW'(1);
        end
        if (src_q == '0) begin
          src_done_d = 1'b1;
          state_d    = (cnt_d != '0) ? eFILL : eDONE;
        end else begin
          src_d = src_q - AW'(1);
        end
      end
      eFILL: begin
        // dst now points at row cnt-1; clear it and everything above.
        write_v_o    = 1'b1;
        write_addr_o = dst_q;
        if (dst_q == '0) state_d = eDONE;
        else             dst_d   = dst_q - AW'(1);
      end
      eDONE: begin
        done_o  = 1'b1;
        state_d = eIDLE;
      end
      default: state_d = eIDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eIDLE;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      src_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      src_done_q <= src_done_d;
    end
  end

  // Zero-fill only ever follows a complete scan.
  a_fill_after_scan: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == eFILL) |-> src_done_q);

endmodule

// File: tb/tb_executor_line_clear.sv
// Directed bench for executor_line_clear with a behavioural board memory.
module tb_executor_line_clear;

  logic            clk = 1'b0;
  logic            reset_i, v_i, ready_o, write_v_o, done_o;
  logic [2:0]      read_addr_o, write_addr_o;
  logic [3:0]      read_data_i, write_data_o, lines_o;
  logic [7:0][3:0] board, load_val;
  logic            load_en;
  int              pass_cnt = 0;
  int              total_cnt = 0;

  executor_line_clear #(.height_p(8), .width_p(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .read_addr_o(read_addr_o), .read_data_i(read_data_i),
    .write_v_o(write_v_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
    .done_o(done_o), .lines_o(lines_o)
  );

  always #5 clk = ~clk;

  assign read_data_i = board[read_addr_o];

  always @(posedge clk) begin
    if (load_en)        board <= load_val;
    else if (write_v_o) board[write_addr_o] <= write_data_o;
  end

  task automatic load_board(input logic [7:0][3:0] b);
    @(negedge clk); load_val = b; load_en = 1'b1;
    @(negedge clk); load_en = 1'b0;
  endtask

  // Start one operation and measure it; cycle 0 is the accept cycle.
  task automatic run_op(output bit got, output int done_c, output int lines,
                        output int scan_w, output int fill_w);
    int c;
    got = 0; done_c = -1; lines = -1; scan_w = 0; fill_w = 0;
    @(negedge clk); v_i = 1'b1;
    @(negedge clk); v_i = 1'b0; c = 1;
    while (!got && c < 40) begin
      if (write_v_o) begin
        if (c <= 8) scan_w++;
        else        fill_w++;
      end
      if (done_o) begin
        got = 1; done_c = c; lines = int'(lines_o);
      end else begin
        @(negedge clk); c++;
      end
    end
  endtask

  task automatic test_reset;
    reset_i = 1'b1; v_i = 1'b0; load_en = 1'b1; load_val = '0;
    repeat (2) @(negedge clk);
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_ready: got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (write_v_o !== 1'b0) $display("FAIL rst_write_v: got %b want 0", write_v_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL rst_done: got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (lines_o !== 4'd0) $display("FAIL rst_lines: got %0d want 0", lines_o); else pass_cnt++;
    total_cnt++; if (write_addr_o !== 3'd0) $display("FAIL rst_waddr: got %0d want 0", write_addr_o); else pass_cnt++;
    total_cnt++; if (write_data_o !== 4'd0) $display("FAIL rst_wdata: got %h want 0", write_data_o); else pass_cnt++;
    reset_i = 1'b0; load_en = 1'b0;
    @(negedge clk);
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", ready_o); else pass_cnt++;
  endtask

  // Shared by the four board scenarios: compare measured results with the hand-computed ones.
  task automatic test_scenario(input string nm, input logic [7:0][3:0] init_b,
                               input logic [7:0][3:0] exp_b, input int exp_done,
                               input int exp_lines, input int exp_sw, input int exp_fw);
    bit got; int dc, ln, sw, fw;
    load_board(init_b);
    run_op(got, dc, ln, sw, fw);
    total_cnt++; if (!got || dc != exp_done) $display("FAIL %s_done_cycle: got %0d want %0d", nm, dc, exp_done); else pass_cnt++;
    total_cnt++; if (ln != exp_lines) $display("FAIL %s_lines: got %0d want %0d", nm, ln, exp_lines); else pass_cnt++;
    total_cnt++; if (sw != exp_sw) $display("FAIL %s_scan_writes: got %0d want %0d", nm, sw, exp_sw); else pass_cnt++;
    total_cnt++; if (fw != exp_fw) $display("FAIL %s_fill_writes: got %0d want %0d", nm, fw, exp_fw); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (board !== exp_b) $display("FAIL %s_board: got %h want %h", nm, board, exp_b); else pass_cnt++;
    total_cnt++; if (ready_o !== 1'b1 || done_o !== 1'b0) $display("FAIL %s_after_done: got ready=%b done=%b want ready=1 done=0", nm, ready_o, done_o); else pass_cnt++;
    total_cnt++; if (int'(lines_o) != exp_lines) $display("FAIL %s_lines_held: got %0d want %0d", nm, lines_o, exp_lines); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int a1, d1, a2, d2, early, c;
    a1 = -1; d1 = -1; a2 = -1; d2 = -1; early = 0;
    load_board('0);
    @(negedge clk); v_i = 1'b1;
    for (c = 0; c < 40; c++) begin
      if (v_i && ready_o) begin
        if (a1 < 0) a1 = c;
        else if (d1 >= 0) a2 = c;
        else early++;
      end
      if (done_o && d1 < 0) d1 = c;
      if (a2 >= 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1 v_i = 1'b0;
    for (int k = 0; k < 40 && d2 < 0; k++) begin
      @(negedge clk); c++;
      if (done_o) d2 = c;
    end
    total_cnt++; if (a1 != 0) $display("FAIL b2b_first_accept: got %0d want 0", a1); else pass_cnt++;
    total_cnt++; if (d1 != 9) $display("FAIL b2b_first_done: got %0d want 9", d1); else pass_cnt++;
    total_cnt++; if (early != 0) $display("FAIL b2b_early_ready: got %0d want 0", early); else pass_cnt++;
    total_cnt++; if (a2 != 10) $display("FAIL b2b_second_accept: got %0d want 10", a2); else pass_cnt++;
    total_cnt++; if (d2 != 19) $display("FAIL b2b_second_done: got %0d want 19", d2); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int pulses;
    bit got; int dc, ln, sw, fw;
    pulses = 0;
    load_board(32'hF5F3_0000);
    @(negedge clk); v_i = 1'b1;
    @(negedge clk); v_i = 1'b0;
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL midrst_ready: got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (write_v_o !== 1'b0) $display("FAIL midrst_write_v: got %b want 0", write_v_o); else pass_cnt++;
    reset_i = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    total_cnt++; if (pulses != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", pulses); else pass_cnt++;
    load_board(32'hF5F3_0000);
    run_op(got, dc, ln, sw, fw);
    total_cnt++; if (!got || dc != 11) $display("FAIL midrst_restart_done: got %0d want 11", dc); else pass_cnt++;
    total_cnt++; if (ln != 2) $display("FAIL midrst_restart_lines: got %0d want 2", ln); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (board !== 32'h5300_0000) $display("FAIL midrst_restart_board: got %h want 53000000", board); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_scenario("empty",   32'h0000_0000, 32'h0000_0000,  9, 0, 0, 0);
    test_scenario("bottom",  32'hF000_0000, 32'h0000_0000, 10, 1, 7, 1);
    test_scenario("mixed",   32'hF5F3_0000, 32'h5300_0000, 11, 2, 6, 2);
    test_scenario("allfull", 32'hFFFF_FFFF, 32'h0000_0000, 17, 8, 0, 8);
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/executor_line_clear.md
# executor_line_clear

Board line-clear stage of the Tetris executor; runs directly downstream of the new-tile executor, once a tile has been locked into the board. On a start pulse it scans the board register file bottom-to-top, one row per cycle. Full rows are dropped, surviving rows are compacted downward, and the vacated top rows are zero-filled. It reports the number of lines cleared for scoring and speed-up logic.

## Interface
- height_p, 32: board rows; row 0 is the top, row height_p-1 is the bottom; legal range 2..32, power of two not required.
- width_p, 16: board columns; bit i of a row is column i; legal range 2..16.
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  start request; accepted only when ready_o=1.
- ready_o  out  1  high in eIDLE only.
- read_addr_o  out  $clog2(height_p)  board row to read.
- read_data_i  in  width_p  row contents; combinational (same-cycle) read of read_addr_o.
- write_v_o  out  1  board write enable for this cycle.
- write_addr_o  out  $clog2(height_p)  board row to write.
- write_data_o  out  width_p  row data to write.
- done_o  out  1  one-cycle pulse when the board is consistent again.
- lines_o  out  $clog2(height_p+1)  lines cleared by the last operation; valid from done_o, held until the next accept.

## Operation
- Registers:
  - src: next row to read.
  - dst: next row to write.
  - cnt: lines cleared.
  - src_done: flag, set when row 0 has been read.
- Row full ⇔ &read_data_i.
- eIDLE: ready_o=1, write_v_o=0. On v_i, set src=dst=height_p-1, cnt=0, src_done=0, then go to eSCAN.
- eSCAN (one row per cycle): read_addr_o=src.
  - Row full: cnt++, no write, dst unchanged.
  - Row not full: if src≠dst, write_v_o=1, write_addr_o=dst, write_data_o=read_data_i. If src=dst, no write, because the row is already in place. Then dst--.
  - If src=0: leave for eFILL if cnt>0, otherwise go to eDONE. Else src--.
- eFILL: write_v_o=1, write_addr_o=dst, write_data_o=0.
  - If dst=0, go to eDONE. Else dst--.
  - Exactly cnt rows are written (rows cnt-1..0).
- eDONE: done_o=1 for one cycle, lines_o=cnt, then return to eIDLE.
- Pointers never wrap: every transition that would decrement past 0 instead leaves the state.
- v_i outside eIDLE is ignored, with no queuing.
- read_addr_o outside eSCAN is don't-care; a bench must not check it.

## Timing
- Reset values: state=eIDLE, ready_o=1, write_v_o=0, done_o=0, lines_o=0, write_addr_o=0, write_data_o=0.
- Accept at cycle 0 (v_i & ready_o sampled). eSCAN occupies cycles 1..height_p. eFILL occupies the next cnt cycles. done_o is asserted at cycle height_p+cnt+1. ready_o rises the following cycle.
- Minimum back-to-back period: height_p+cnt+2 cycles.
- Write outputs are combinational from state and read_data_i; the board samples them on the same rising edge.
- The block assumes it is the sole board writer while ready_o=0. The upstream new-tile executor must not write during that window.
- Reset asserted mid-operation: the next edge returns the block to eIDLE with write_v_o=0. The board may be left partially compacted; the top-level restarts the game in that case.
- Worst case, all rows full: cnt=height_p, no scan writes, height_p fill writes, lines_o=height_p, which needs the +1 width.

## Structure
- The shared package tetris_pkg holds:
  - the state enum type (eIDLE, eSCAN, eFILL, eDONE), shared with the other executor stages;
  - the row-full reduction as a function.
- No sub-module is needed; the datapath is two pointers, a counter and one AND reduction.

## Test plan
All scenarios use height_p=8, width_p=4.
- Empty board, start:
  - 8 scan cycles with no writes, no fill;
  - done_o at cycle 9, lines_o=0;
  - board unchanged.
- Row 7=F, rows 6..0=0, start:
  - 7 scan writes of row k→k+1 (rows 6..0), then 1 zero-fill of row 0;
  - done_o at cycle 10, lines_o=1;
  - board all 0.
- Rows 7=F, 6=5, 5=F, 4=3, rest 0:
  - final board row7=5, row6=3, rows 5..0=0;
  - lines_o=2, done_o at cycle 11.
- All rows F:
  - no scan writes, 8 fill writes (rows 7..0 to 0);
  - lines_o=8, done_o at cycle 17.
- v_i held high throughout:
  - second accept occurs only at the cycle after done_o;
  - no start is dropped mid-scan.
- reset_i asserted at cycle 4 of a scan:
  - next cycle ready_o=1, write_v_o=0, done_o never pulses;
  - a fresh start then completes normally.
